// File: rtl/sindoku_board_ctrl_if.sv
// Button/switch inputs and status/cursor outputs of the SINdoku board engine.
// err_count exists only when SINDOKU_ERRCNT_EN is defined.
interface sindoku_board_ctrl_if;
  logic       R;
  logic       L;
  logic       U;
  logic       D;
  logic       C;
  logic       CheckSolu;
  logic [3:0] userIn;
  logic       q_I;
  logic       q_Solve;
  logic       q_Check;
  logic       q_Correct;
  logic       q_Incorrect;
  logic [3:0] cur_row;
  logic [3:0] cur_col;
  logic [3:0] cur_val;
  logic       cur_given;
`ifdef SINDOKU_ERRCNT_EN
  logic [4:0] err_count;
`endif

  modport master (
    output R, L, U, D, C, CheckSolu, userIn,
    input  q_I, q_Solve, q_Check, q_Correct, q_Incorrect,
    input  cur_row, cur_col, cur_val, cur_given
`ifdef SINDOKU_ERRCNT_EN
    , input err_count
`endif
  );

  modport slave (
    input  R, L, U, D, C, CheckSolu, userIn,
    output q_I, q_Solve, q_Check, q_Correct, q_Incorrect,
    output cur_row, cur_col, cur_val, cur_given
`ifdef SINDOKU_ERRCNT_EN
    , output err_count
`endif
  );
endinterface

// File: rtl/sindoku_board_ctrl.sv
// SINdoku engine: board load, cursor/entry editing and 27-group rule check; cursor outputs lag inputs by one cycle.
// No backpressure: inputs are single-cycle pulses. SINDOKU_ERRCNT_EN selects a full scan with bad-group count.
module sindoku_board_ctrl #(
  parameter logic [323:0] PUZZLE   = 324'h0,
  parameter logic [3:0]   CUR_ROW0 = 4'd4,
  parameter logic [3:0]   CUR_COL0 = 4'd4
) (
  input logic                 Clk,
  input logic                 Reset_n,
  sindoku_board_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_INI, S_SOLVE, S_CHECK, S_CORRECT, S_INCORRECT
  } state_e;

  function automatic logic [6:0] cell_idx(input logic [3:0] r, input logic [3:0] c);
    return {3'b000, r} * 7'd9 + {3'b000, c};
  endfunction

  function automatic logic [3:0] div3(input logic [3:0] x);
    if (x >= 4'd6)      return 4'd2;
    else if (x >= 4'd3) return 4'd1;
    else                return 4'd0;
  endfunction

  function automatic logic [3:0] mod3(input logic [3:0] x);
    return x - 4'd3 * div3(x);
  endfunction

  state_e     state_q, state_d;
  logic [6:0] ld_idx_q, ld_idx_d;
  logic [3:0] row_q, row_d, col_q, col_d;
  logic       chk_prev_q;
  logic [3:0] cur_val_q, cur_val_d;
  logic       cur_given_q, cur_given_d;
  logic [4:0] grp_q, grp_d;
  logic [3:0] k_q, k_d;
  logic [8:0] seen_q, seen_d;
  logic       gbad_q, gbad_d;
  logic       dec_q, dec_d;
`ifdef SINDOKU_ERRCNT_EN
  logic [4:0] err_q, err_d;
`else
  logic       fail_q, fail_d;
`endif

  logic [3:0]  val_mem [81];
  logic [80:0] given_mem;

  logic       wr_en, wr_given;
  logic [6:0] wr_idx, nxt_idx;
  logic [3:0] wr_val;
  logic       rise;

  logic [3:0] chk_r, chk_c, chk_b, chk_v;
  logic [8:0] v_onehot, seen_base;
  logic       bad_elem, gbad_eff;

  assign rise = bus.CheckSolu & ~chk_prev_q;

  // Cell visited by the checker for group grp_q, element k_q.
  always_comb begin
    chk_r = 4'd0;
    chk_c = 4'd0;
    chk_b = grp_q[3:0] - 4'd2;
    if (grp_q < 5'd9) begin
      chk_r = grp_q[3:0];
      chk_c = k_q;
    end else if (grp_q < 5'd18) begin
      chk_r = k_q;
      chk_c = grp_q[3:0] - 4'd9;
    end else begin
      chk_r = 4'd3 * div3(chk_b) + div3(k_q);
      chk_c = 4'd3 * mod3(chk_b) + mod3(k_q);
    end
    chk_v     = val_mem[cell_idx(chk_r, chk_c)];
    v_onehot  = 9'd1 << (chk_v - 4'd1);
    seen_base = (k_q == 4'd0) ? 9'd0 : seen_q;
    bad_elem  = (chk_v == 4'd0) || (chk_v > 4'd9) || ((seen_base & v_onehot) != 9'd0);
    gbad_eff  = ((k_q != 4'd0) && gbad_q) || bad_elem;
  end

  always_comb begin
    state_d     = state_q;
    ld_idx_d    = ld_idx_q;
    row_d       = row_q;
    col_d       = col_q;
    cur_val_d   = cur_val_q;
    cur_given_d = cur_given_q;
    grp_d       = grp_q;
    k_d         = k_q;
    seen_d      = seen_q;
    gbad_d      = gbad_q;
    dec_d       = dec_q;
`ifdef SINDOKU_ERRCNT_EN
    err_d       = err_q;
`else
    fail_d      = fail_q;
`endif
    wr_en       = 1'b0;
    wr_idx      = cell_idx(row_q, col_q);
    wr_val      = bus.userIn;
    wr_given    = 1'b0;

    case (state_q)
      S_INI: begin
        wr_en    = 1'b1;
        wr_idx   = ld_idx_q;
        wr_val   = PUZZLE[{ld_idx_q, 2'b00} +: 4];
        wr_given = (wr_val != 4'd0);
        ld_idx_d = ld_idx_q + 7'd1;
        if (ld_idx_q == 7'd80) state_d = S_SOLVE;
      end
      S_SOLVE: begin
        if (bus.C && !given_mem[wr_idx] && (bus.userIn <= 4'd9)) wr_en = 1'b1;
        if (bus.R && !bus.L)      col_d = (col_q == 4'd8) ? 4'd0 : col_q + 4'd1;
        else if (bus.L && !bus.R) col_d = (col_q == 4'd0) ? 4'd8 : col_q - 4'd1;
        if (bus.U && !bus.D)      row_d = (row_q == 4'd0) ? 4'd8 : row_q - 4'd1;
        else if (bus.D && !bus.U) row_d = (row_q == 4'd8) ? 4'd0 : row_q + 4'd1;
        if (rise) begin
          state_d = S_CHECK;
          grp_d   = 5'd0;
          k_d     = 4'd0;
          seen_d  = 9'd0;
          gbad_d  = 1'b0;
          dec_d   = 1'b0;
`ifdef SINDOKU_ERRCNT_EN
          err_d   = 5'd0;
`else
          fail_d  = 1'b0;
`endif
        end
      end
      S_CHECK: begin
        if (dec_q) begin
`ifdef SINDOKU_ERRCNT_EN
          state_d = (err_q != 5'd0) ? S_INCORRECT : S_CORRECT;
`else
          state_d = fail_q ? S_INCORRECT : S_CORRECT;
`endif
        end else begin
          seen_d = seen_base | v_onehot;
          gbad_d = gbad_eff;
          if (k_q == 4'd8) begin
            k_d   = 4'd0;
            grp_d = grp_q + 5'd1;
`ifdef SINDOKU_ERRCNT_EN
            if (gbad_eff) err_d = err_q + 5'd1;
            if (grp_q == 5'd26) dec_d = 1'b1;
`else
            if (gbad_eff) begin
              fail_d = 1'b1;
              dec_d  = 1'b1;
            end else if (grp_q == 5'd26) begin
              dec_d  = 1'b1;
            end
`endif
          end else begin
            k_d = k_q + 4'd1;
          end
        end
      end
      S_CORRECT: ;
      S_INCORRECT: if (!bus.CheckSolu) state_d = S_SOLVE;
      default: state_d = S_INI;
    endcase

    // Forward a same-cycle write so cur_val never shows a stale cell.
    nxt_idx = cell_idx(row_d, col_d);
    if (wr_en && (wr_idx == nxt_idx)) begin
      cur_val_d   = wr_val;
      cur_given_d = wr_given;
    end else if (state_q != S_INI) begin
      cur_val_d   = val_mem[nxt_idx];
      cur_given_d = given_mem[nxt_idx];
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q     <= S_INI;
      ld_idx_q    <= 7'd0;
      row_q       <= CUR_ROW0;
      col_q       <= CUR_COL0;
      chk_prev_q  <= 1'b0;
      cur_val_q   <= 4'd0;
      cur_given_q <= 1'b0;
      grp_q       <= 5'd0;
      k_q         <= 4'd0;
      seen_q      <= 9'd0;
      gbad_q      <= 1'b0;
      dec_q       <= 1'b0;
`ifdef SINDOKU_ERRCNT_EN
      err_q       <= 5'd0;
`else
      fail_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ld_idx_q    <= ld_idx_d;
      row_q       <= row_d;
      col_q       <= col_d;
      chk_prev_q  <= bus.CheckSolu;
      cur_val_q   <= cur_val_d;
      cur_given_q <= cur_given_d;
      grp_q       <= grp_d;
      k_q         <= k_d;
      seen_q      <= seen_d;
      gbad_q      <= gbad_d;
      dec_q       <= dec_d;
`ifdef SINDOKU_ERRCNT_EN
      err_q       <= err_d;
`else
      fail_q      <= fail_d;
`endif
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset_n && wr_en) begin
      val_mem[wr_idx]   <= wr_val;
      given_mem[wr_idx] <= wr_given;
    end
  end

  assign bus.q_I         = (state_q == S_INI);
  assign bus.q_Solve     = (state_q == S_SOLVE);
  assign bus.q_Check     = (state_q == S_CHECK);
  assign bus.q_Correct   = (state_q == S_CORRECT);
  assign bus.q_Incorrect = (state_q == S_INCORRECT);
  assign bus.cur_row     = row_q;
  assign bus.cur_col     = col_q;
  assign bus.cur_val     = cur_val_q;
  assign bus.cur_given   = cur_given_q;
`ifdef SINDOKU_ERRCNT_EN
  assign bus.err_count   = err_q;
`endif

endmodule

// File: tb/tb_sindoku_board_ctrl.sv
// Directed scoreboard bench for sindoku_board_ctrl: stimulus queues expectations, a negedge monitor compares them.
module tb_sindoku_board_ctrl;

  // Valid solution with cell (0,0) blanked; cell 0 is the lowest nibble.
  localparam logic [323:0] PUZ =
    324'h971682543_536914782_482735169_658429317_197358624_324167958_765243891_843591276_219876430;

  localparam logic [4:0] ST_INI  = 5'b10000;
  localparam logic [4:0] ST_SOLV = 5'b01000;
  localparam logic [4:0] ST_CHK  = 5'b00100;
  localparam logic [4:0] ST_OK   = 5'b00010;
  localparam logic [4:0] ST_BAD  = 5'b00001;

  typedef enum int {F_STATE, F_ROW, F_COL, F_VAL, F_GIVEN, F_PLEN, F_ERR} fld_e;
  typedef struct {
    fld_e  fld;
    int    exp;
    string name;
  } exp_t;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  sindoku_board_ctrl_if bus();

  sindoku_board_ctrl #(.PUZZLE(PUZ), .CUR_ROW0(4'd4), .CUR_COL0(4'd4)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  exp_t       sb_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         run_len = 0;
  int         prev_len = 0;
  logic [4:0] prev_st = 5'b0;

  function automatic logic [4:0] st_vec();
    return {bus.q_I, bus.q_Solve, bus.q_Check, bus.q_Correct, bus.q_Incorrect};
  endfunction

  // Monitor: tracks how long each state lasted and checks every queued expectation.
  always @(negedge Clk) begin : monitor
    logic [4:0] s;
    exp_t       e;
    int         act;
    s = st_vec();
    if (!Reset_n) begin
      run_len = 0;
      prev_st = s;
    end else if (s == prev_st) begin
      run_len++;
    end else begin
      prev_len = run_len;
      run_len  = 1;
      prev_st  = s;
    end
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.fld)
        F_STATE: act = int'(s);
        F_ROW:   act = int'(bus.cur_row);
        F_COL:   act = int'(bus.cur_col);
        F_VAL:   act = int'(bus.cur_val);
        F_GIVEN: act = int'(bus.cur_given);
        F_PLEN:  act = prev_len;
`ifdef SINDOKU_ERRCNT_EN
        F_ERR:   act = int'(bus.err_count);
`endif
        default: act = -1;
      endcase
      n_cmp++;
      if (act != e.exp) begin
        n_bad++;
        $display("FAIL %s: got %0d expected %0d", e.name, act, e.exp);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic expect_v(input fld_e f, input int v, input string nm);
    exp_t e;
    e.fld  = f;
    e.exp  = v;
    e.name = nm;
    sb_q.push_back(e);
  endtask

  task automatic press(input logic r, input logic l, input logic u, input logic d, input logic c);
    bus.R = r; bus.L = l; bus.U = u; bus.D = d; bus.C = c;
    tick(1);
    bus.R = 1'b0; bus.L = 1'b0; bus.U = 1'b0; bus.D = 1'b0; bus.C = 1'b0;
    tick(1);
  endtask

  task automatic wait_state(input logic [4:0] target, input int limit, input string nm);
    int n;
    n = 0;
    while (st_vec() != target && n < limit) begin
      tick(1);
      n++;
    end
    if (st_vec() != target) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timeout after %0d cycles, state %b expected %b", nm, n, st_vec(), target);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    bus.R = 1'b0; bus.L = 1'b0; bus.U = 1'b0; bus.D = 1'b0; bus.C = 1'b0;
    bus.CheckSolu = 1'b0;
    bus.userIn = 4'd0;
    Reset_n = 1'b0;
    tick(3);
    expect_v(F_STATE, ST_INI, "reset_state");
    expect_v(F_VAL, 0, "reset_val");
    expect_v(F_GIVEN, 0, "reset_given");
    expect_v(F_ROW, 4, "reset_row");
    expect_v(F_COL, 4, "reset_col");
    Reset_n = 1'b1;

    wait_state(ST_SOLV, 200, "ini_done");
    expect_v(F_PLEN, 81, "ini_len");
    expect_v(F_VAL, 5, "ini_cell40_val");
    expect_v(F_GIVEN, 1, "ini_cell40_given");

    repeat (4) press(1, 0, 0, 0, 0);
    expect_v(F_COL, 8, "move_col8");
    press(1, 0, 0, 0, 0);
    expect_v(F_COL, 0, "wrap_right");
    expect_v(F_ROW, 4, "wrap_right_row");
    repeat (5) press(0, 0, 1, 0, 0);
    expect_v(F_ROW, 8, "wrap_up");
    press(1, 1, 0, 0, 0);
    expect_v(F_COL, 0, "rl_cancel");
    press(0, 0, 1, 1, 0);
    expect_v(F_ROW, 8, "ud_cancel");
    expect_v(F_VAL, 3, "cell80_val");
    press(0, 0, 0, 1, 0);
    expect_v(F_ROW, 0, "wrap_down");
    press(0, 1, 0, 0, 0);
    expect_v(F_COL, 8, "wrap_left");
    expect_v(F_VAL, 2, "cell8_val");
    press(1, 0, 0, 0, 0);
    repeat (4) press(1, 0, 0, 0, 0);
    expect_v(F_VAL, 7, "given7_val");

    bus.userIn = 4'd3;
    press(0, 0, 0, 0, 1);
    expect_v(F_VAL, 7, "given_write_ignored");
    expect_v(F_GIVEN, 1, "given_flag");
    repeat (4) press(0, 1, 0, 0, 0);
    expect_v(F_VAL, 0, "blank_val");
    expect_v(F_GIVEN, 0, "blank_given");
    bus.userIn = 4'd12;
    press(0, 0, 0, 0, 1);
    expect_v(F_VAL, 0, "userin12_ignored");
    bus.userIn = 4'd5;
    press(0, 0, 0, 0, 1);
    expect_v(F_VAL, 5, "write5");

    bus.CheckSolu = 1'b1;
    tick(1);
    wait_state(ST_OK, 400, "check_correct");
    expect_v(F_PLEN, 244, "check_len_correct");
`ifdef SINDOKU_ERRCNT_EN
    expect_v(F_ERR, 0, "errcnt_correct");
`endif
    press(1, 0, 0, 0, 0);
    expect_v(F_STATE, ST_OK, "correct_held_btn");
    bus.CheckSolu = 1'b0;
    tick(2);
    expect_v(F_STATE, ST_OK, "correct_held_sw");

    Reset_n = 1'b0;
    tick(2);
    Reset_n = 1'b1;
    wait_state(ST_SOLV, 200, "reload_done");
    expect_v(F_VAL, 5, "reload_cell40");
    repeat (4) press(0, 0, 1, 0, 0);
    repeat (4) press(0, 1, 0, 0, 0);
    expect_v(F_VAL, 0, "reload_blank");
    bus.userIn = 4'd6;
    press(0, 0, 0, 0, 1);
    expect_v(F_VAL, 6, "write6");

    bus.CheckSolu = 1'b1;
    tick(1);
    wait_state(ST_BAD, 400, "check_incorrect");
`ifdef SINDOKU_ERRCNT_EN
    expect_v(F_PLEN, 244, "check_len_incorrect");
    expect_v(F_ERR, 3, "errcnt_bad_groups");
`else
    expect_v(F_PLEN, 10, "check_len_incorrect");
`endif
    tick(3);
    expect_v(F_STATE, ST_BAD, "incorrect_held");
    bus.CheckSolu = 1'b0;
    tick(2);
    expect_v(F_STATE, ST_SOLV, "back_to_solve");
    expect_v(F_VAL, 6, "board_kept");
    expect_v(F_ROW, 0, "cursor_row_kept");
    expect_v(F_COL, 0, "cursor_col_kept");

    bus.CheckSolu = 1'b1;
    tick(5);
    expect_v(F_STATE, ST_CHK, "mid_check");
    Reset_n = 1'b0;
    tick(1);
    expect_v(F_STATE, ST_INI, "reset_mid_check");
    Reset_n = 1'b1;
    bus.CheckSolu = 1'b0;
    wait_state(ST_SOLV, 200, "reload2_done");
    expect_v(F_PLEN, 81, "ini_len2");
    expect_v(F_ROW, 4, "reload2_row");
    expect_v(F_COL, 4, "reload2_col");
    expect_v(F_VAL, 5, "reload2_cell40");
    repeat (4) press(0, 0, 1, 0, 0);
    repeat (4) press(0, 1, 0, 0, 0);
    expect_v(F_VAL, 0, "reload2_blank");
    expect_v(F_GIVEN, 0, "reload2_blank_given");

    tick(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
